// File: rtl/pipeline_pkg.sv
// Shared pipeline types: packed inter-stage payload structs and the stall-counter width.
package pipeline_pkg;

  localparam int PIPE_STALL_CNT_WIDTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        mem_to_reg;
  } dec_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  dst;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] load_val;
    logic [4:0]  dst;
    logic        reg_wr;
    logic        mem_to_reg;
  } mem_wb_t;

endpackage

// File: rtl/pipeline_skid_slot.sv
// One valid+payload register. Priority: clear > load > unload.
module pipeline_skid_slot
  import pipeline_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter bit ZERO_ON_EMPTY = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             unload,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      valid <= 1'b0;
      if (ZERO_ON_EMPTY) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (unload) begin
      valid <= 1'b0;
      if (ZERO_ON_EMPTY) data <= '0;
    end
  end

endmodule

// File: rtl/pipeline_stage_register.sv
// Inter-stage register with valid/ready, flush and a saturating stall counter.
// Define PIPELINE_STAGE_REGISTER_SKID_EN to add a one-entry skid buffer (registered in_ready).
module pipeline_stage_register
  import pipeline_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int CNT_WIDTH     = PIPE_STALL_CNT_WIDTH,
  parameter bit ZERO_ON_EMPTY = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 stall_clear,
  output logic [CNT_WIDTH-1:0] stall_count
);

  logic             up_xfer;
  logic             dn_xfer;
  logic             main_load;
  logic [WIDTH-1:0] main_din;

  assign up_xfer = in_valid && in_ready;
  assign dn_xfer = out_valid && out_ready;

`ifdef PIPELINE_STAGE_REGISTER_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_load;

  // skid_valid is a flop, so in_ready has no combinational input path
  assign in_ready  = !skid_valid;
  assign skid_load = up_xfer && out_valid && !out_ready;
  // skid can only be full while main is full, so it always refills main first
  assign main_load = (dn_xfer && skid_valid) || (up_xfer && (!out_valid || out_ready));
  assign main_din  = skid_valid ? skid_data : in_data;

  pipeline_skid_slot #(
    .WIDTH         (WIDTH),
    .ZERO_ON_EMPTY (ZERO_ON_EMPTY)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .load      (skid_load),
    .load_data (in_data),
    .unload    (dn_xfer),
    .valid     (skid_valid),
    .data      (skid_data)
  );
`else
  assign in_ready  = !out_valid || out_ready;
  assign main_load = up_xfer;
  assign main_din  = in_data;
`endif

  pipeline_skid_slot #(
    .WIDTH         (WIDTH),
    .ZERO_ON_EMPTY (ZERO_ON_EMPTY)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .load      (main_load),
    .load_data (main_din),
    .unload    (dn_xfer),
    .valid     (out_valid),
    .data      (out_data)
  );

  always_ff @(posedge clk) begin
    if (!reset || stall_clear)
      stall_count <= '0;
    else if (out_valid && !out_ready && !flush && (stall_count != {CNT_WIDTH{1'b1}}))
      stall_count <= stall_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Directed bench for pipeline_stage_register; skid checks follow PIPELINE_STAGE_REGISTER_SKID_EN.
module tb_pipeline_stage_register;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready, stall_clear;
  logic [31:0] in_data, out_data;
  logic [15:0] stall_count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_stall_clear;
  logic [7:0]  s_in_data, s_out_data;
  logic [2:0]  s_stall_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_stage_register #(.WIDTH(32), .CNT_WIDTH(16), .ZERO_ON_EMPTY(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_clear(stall_clear), .stall_count(stall_count)
  );

  pipeline_stage_register #(.WIDTH(8), .CNT_WIDTH(3), .ZERO_ON_EMPTY(1'b0)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .flush(1'b0), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .stall_clear(s_stall_clear), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    flush = 1'b0; stall_clear = 1'b0;
    s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b1; s_stall_clear = 1'b0;

    // reset with upstream driving
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_cnt", {16'd0, stall_count}, 32'd0);
    chk("rst_sat_valid", {31'd0, s_out_valid}, 32'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_data", out_data, 32'hDEADBEEF);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_zero", out_data, 32'd0);

    // streaming, no bubble
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = i;
      #1 chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", out_data, i);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", {31'd0, out_valid}, 32'd0);

    // back-pressure: 5 stall cycles holding 0xA5
    in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b0;
    tick();
    chk("bp_load", out_data, 32'hA5);
`ifdef PIPELINE_STAGE_REGISTER_SKID_EN
    in_data = 32'h5A;
    #1 chk("bp_skid_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_skid_full", {31'd0, in_ready}, 32'd0);
    repeat (4) tick();
`else
    in_valid = 1'b0;
    repeat (5) tick();
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
`endif
    chk("bp_hold", out_data, 32'hA5);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_cnt", {16'd0, stall_count}, 32'd5);
    out_ready = 1'b1;
    #1 chk("bp_first_out", out_data, 32'hA5);
    tick();
`ifdef PIPELINE_STAGE_REGISTER_SKID_EN
    chk("bp_second_out", out_data, 32'h5A);
    chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
`endif
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_cnt_kept", {16'd0, stall_count}, 32'd5);
    stall_clear = 1'b1;
    tick();
    stall_clear = 1'b0;
    chk("clr_cnt", {16'd0, stall_count}, 32'd0);

    // flush while holding 0x11 (and 0x22 in skid)
    in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
    tick();
`ifdef PIPELINE_STAGE_REGISTER_SKID_EN
    in_data = 32'h22;
    tick();
`endif
    in_data = 32'h33; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_data", out_data, 32'd0);
`ifdef PIPELINE_STAGE_REGISTER_SKID_EN
    chk("flush_cnt", {16'd0, stall_count}, 32'd1);
    chk("flush_skid_empty", {31'd0, in_ready}, 32'd1);
`else
    chk("flush_cnt", {16'd0, stall_count}, 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    chk("flush_no_33", {31'd0, out_valid}, 32'd0);
    // upstream transfer accepted in the flush cycle is discarded
    in_valid = 1'b1; in_data = 32'h44; flush = 1'b1;
    #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_in", {31'd0, out_valid}, 32'd0);
    tick();
    chk("flush_drop_in2", {31'd0, out_valid}, 32'd0);

    // saturation on the 3-bit counter instance
    s_in_valid = 1'b1; s_in_data = 8'h7E; s_out_ready = 1'b0;
    tick();
    s_in_valid = 1'b0;
    repeat (10) tick();
    chk("sat_cnt", {29'd0, s_stall_count}, 32'd7);
    s_stall_clear = 1'b1;
    tick();
    chk("sat_clear", {29'd0, s_stall_count}, 32'd0);
    s_stall_clear = 1'b0;
    tick();
    chk("sat_restart", {29'd0, s_stall_count}, 32'd1);
    s_out_ready = 1'b1;
    tick();
    chk("sat_drain_valid", {31'd0, s_out_valid}, 32'd0);
    chk("sat_hold_data", {24'd0, s_out_data}, 32'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_register.md
# pipeline_stage_register

Parametrised inter-stage pipeline register that replaces the fixed, always-advancing stage registers between the decode, execute, memory and writeback stages. It carries an opaque WIDTH-bit payload with a valid/ready handshake, flush and back-pressure, and holds its payload when downstream stalls. It also keeps a saturating stall-cycle counter for performance debugging. The MIPS core instantiates one per stage boundary and packs its control and datapath fields into the payload.

## Interface
Parameters:
- WIDTH, 32: payload width in bits, minimum 1.
- CNT_WIDTH, 16: width of the stall counter, minimum 1.
- ZERO_ON_EMPTY, 1: 1 clears the payload to 0 on reset, on flush and on drain; 0 leaves the payload holding its last value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- flush  input  1  kills all held payloads (branch or exception squash).
- out_valid  output  1  held payload valid.
- out_ready  input  1  downstream accepts a payload this cycle.
- out_data  output  WIDTH  held payload.
- stall_clear  input  1  zeroes the stall counter.
- stall_count  output  CNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Handshakes:
  - An upstream transfer occurs when in_valid && in_ready.
  - A downstream transfer occurs when out_valid && out_ready.
  - in_valid and in_data are ignored whenever in_ready=0.
- Reset (reset=0 at a clock edge):
  - out_valid=0, stall_count=0, skid buffer empty.
  - out_data=0 if ZERO_ON_EMPTY=1, otherwise the payload keeps its value.
  - Reset applied mid-transfer discards all held payloads.
- Base mode (skid buffer compiled out):
  - in_ready = !out_valid || out_ready, combinational.
  - Upstream transfer: out_data <= in_data, out_valid <= 1.
  - Downstream transfer with no upstream transfer in the same cycle: out_valid <= 0. out_data is cleared if ZERO_ON_EMPTY=1.
  - Downstream and upstream transfer in the same cycle: pass-through with no bubble.
- Flush:
  - Has priority over every transfer. Next cycle out_valid=0 and the skid buffer is empty.
  - The payload is cleared if ZERO_ON_EMPTY=1.
  - An upstream transfer in the flush cycle is consumed and discarded. in_ready does not depend on flush.
- Stall counter:
  - Increments in every cycle where out_valid && !out_ready && !flush.
  - Saturates at 2^CNT_WIDTH-1.
  - stall_clear has priority over increment; the counter reads 0 on the next cycle.

## Timing
- Latency from in_data to out_data is 1 cycle in both modes.
- Throughput is 1 payload per cycle under continuous out_ready=1.
- Base mode:
  - in_ready has a combinational path from out_ready.
  - Payloads held: at most 1.
- Skid mode:
  - in_ready is a register output with no combinational input paths.
  - Payloads held: at most 2.
- Held payloads are never reordered, duplicated or dropped, except by flush or reset.

## Configuration
- Macro: PIPELINE_STAGE_REGISTER_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer. in_ready = skid empty, registered.
  - An upstream transfer while out_valid=1 and out_ready=0 loads the skid entry, and in_ready drops on the next cycle.
  - On a downstream transfer, the skid entry moves into the main register in the same edge, and in_ready rises on the next cycle.
- Undefined: base mode as above. No skid storage is synthesised.

## Structure
- Package pipeline_pkg holds:
  - Typedefs of the packed stage payload structs (decode→execute, execute→memory, memory→writeback); each instantiation sets WIDTH = $bits of its struct.
  - Constant PIPE_STALL_CNT_WIDTH = 16.
- One sub-module, pipeline_skid_slot: a single valid+payload register with load/unload/clear. It is instantiated for the main register and, under the macro, for the skid entry.

## Test plan
- Reset:
  - Stimulus: drive in_valid=1, in_data=0xDEADBEEF, reset=0 for 2 cycles.
  - Response: out_valid=0, out_data=0, stall_count=0.
  - Then release reset: out_data=0xDEADBEEF and out_valid=1 one cycle later.
- Streaming:
  - Stimulus: out_ready=1, send 1,2,3,4 on consecutive cycles.
  - Response: out_data=1,2,3,4 on the following consecutive cycles, no bubble, in_ready stays 1.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 5 cycles with 0xA5 held.
  - Response: out_data stays 0xA5, stall_count=5.
  - With the macro: a second payload 0x5A is accepted and in_ready=0 afterwards. After out_ready=1, 0xA5 then 0x5A are delivered in order.
- Flush:
  - Stimulus: flush=1 while holding 0x11 (and 0x22 in the skid entry) with in_valid=1, in_data=0x33.
  - Response: next cycle out_valid=0 and out_data=0. 0x33 is never output.
- Saturation:
  - Stimulus: CNT_WIDTH=3, stall for 10 cycles.
  - Response: stall_count=7. stall_clear=1 gives stall_count=0 next cycle, even if the stall continues.
